// File: rtl/simple_wr_fifo.sv
// First-word-fall-through FIFO controller for an external simple_wr_ram.
// Writes go straight to RAM port B. Reads are prefetched through port A into a
// 2-entry output buffer, which hides the RAM's one-cycle read latency.
module simple_wr_fifo #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [ADDR_WIDTH-1:0] ram_a_addr,
  input  logic [DATA_WIDTH-1:0] ram_a_rddata,
  output logic [ADDR_WIDTH-1:0] ram_b_addr,
  output logic                  ram_b_we,
  output logic [DATA_WIDTH-1:0] ram_b_wrdata,
  output logic [ADDR_WIDTH+1:0] count
);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic                  rd_pend_q;
  logic [1:0]            occ_q, occ_d;
  logic                  head_q;
  logic [DATA_WIDTH-1:0] buf_q [2];

  logic                  push, pop, issue;
  logic                  tail;
  logic [2:0]            held_after_pop;
  logic [ADDR_WIDTH:0]   ram_full;

  assign ram_full = {1'b1, {ADDR_WIDTH{1'b0}}};

  // Push side only looks at registered state, so w_ready never depends on r_ready.
  assign w_ready      = (ram_cnt_q != ram_full);
  assign push         = w_valid && w_ready;
  assign ram_b_we     = push;
  assign ram_b_addr   = wr_ptr_q;
  assign ram_b_wrdata = w_data;

  assign r_valid = (occ_q != 2'd0);
  assign r_data  = buf_q[head_q];
  assign pop     = r_valid && r_ready;

  // Entries that will occupy the buffer once the pending read lands and this pop leaves.
  assign held_after_pop = {1'b0, occ_q} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign issue          = (ram_cnt_q != '0) && (held_after_pop < 3'd2);
  assign ram_a_addr     = rd_ptr_q;

  // A capture only happens when occ <= 1, so the free slot is head + occ (mod 2).
  assign tail = head_q ^ occ_q[0];

  assign count = {1'b0, ram_cnt_q}
               + {{(ADDR_WIDTH+1){1'b0}}, rd_pend_q}
               + {{ADDR_WIDTH{1'b0}}, occ_q};

  // Next-state for pointers, RAM occupancy and buffer occupancy.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !issue) begin
      ram_cnt_d = ram_cnt_q + 1'b1;
    end else if (!push && issue) begin
      ram_cnt_d = ram_cnt_q - 1'b1;
    end
    occ_d = occ_q + {1'b0, rd_pend_q} - {1'b0, pop};
  end

  // State registers; reset drops all queued data and any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      occ_q     <= 2'd0;
      head_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      rd_pend_q <= issue;
      occ_q     <= occ_d;
      head_q    <= head_q ^ pop;
    end
  end

  // Output buffer data; contents are don't-care while their slot is unoccupied.
  always_ff @(posedge clk) begin
    if (!rst && rd_pend_q) begin
      buf_q[tail] <= ram_a_rddata;
    end
  end

endmodule

// File: tb/tb_simple_wr_fifo.sv
// Bench for simple_wr_fifo with ADDR_WIDTH=2 and a behavioural RAM.
// The reference model is a queue of (data, accept cycle): an entry is visible
// at the head three cycles after acceptance, and pushes are refused once
// 2**ADDR_WIDTH + 2 entries are held.
module tb_simple_wr_fifo;

  localparam int unsigned AW  = 2;
  localparam int unsigned DW  = 64;
  localparam int unsigned CAP = (1 << AW) + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          w_valid, w_ready, r_valid, r_ready, ram_b_we;
  logic [DW-1:0] w_data, r_data, ram_a_rddata, ram_b_wrdata;
  logic [AW-1:0] ram_a_addr, ram_b_addr;
  logic [AW+1:0] count;

  int checks = 0;
  int errors = 0;

  simple_wr_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_data       (w_data),
    .r_valid      (r_valid),
    .r_ready      (r_ready),
    .r_data       (r_data),
    .ram_a_addr   (ram_a_addr),
    .ram_a_rddata (ram_a_rddata),
    .ram_b_addr   (ram_b_addr),
    .ram_b_we     (ram_b_we),
    .ram_b_wrdata (ram_b_wrdata),
    .count        (count)
  );

  always #5 clk = ~clk;

  // RAM: write port B, registered read address on port A.
  logic [DW-1:0] mem [1 << AW];
  logic [AW-1:0] ra_q;
  always @(posedge clk) begin
    if (ram_b_we) mem[ram_b_addr] <= ram_b_wrdata;
    ra_q <= ram_a_addr;
  end
  assign ram_a_rddata = mem[ra_q];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model.
  typedef struct {
    logic [DW-1:0] data;
    int unsigned   acc;
  } ent_t;
  ent_t        q[$];
  int unsigned cyc = 0;

  // Compare every cycle at the falling edge, then advance the model.
  always @(negedge clk) begin
    logic exp_wr, exp_rv;
    if (rst) begin
      q.delete();
    end else begin
      exp_wr = (q.size() < CAP);
      exp_rv = (q.size() > 0) && (cyc >= q[0].acc + 3);
      check("count", 64'(count), 64'(q.size()));
      check("w_ready", 64'(w_ready), 64'(exp_wr));
      check("r_valid", 64'(r_valid), 64'(exp_rv));
      check("ram_b_we", 64'(ram_b_we), 64'(w_valid && exp_wr));
      if (exp_rv) check("r_data", r_data, q[0].data);
      if (exp_rv && r_ready) void'(q.pop_front());
      if (w_valid && exp_wr) q.push_back('{data: w_data, acc: cyc});
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int got, pushed, pops, bubbles, k;
    logic seen;
    rst = 1'b1; w_valid = 1'b0; r_ready = 1'b0; w_data = '0;
    repeat (3) tick();
    rst = 1'b0;

    // First post-reset cycle.
    check("rst_w_ready", 64'(w_ready), 64'd1);
    check("rst_r_valid", 64'(r_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_ram_b_we", 64'(ram_b_we), 64'd0);
    check("rst_ram_a_addr", 64'(ram_a_addr), 64'd0);

    // Single word: r_valid exactly 3 cycles after accept.
    w_valid = 1'b1; w_data = 64'hA1; r_ready = 1'b1;
    tick();
    w_valid = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      check("lat_r_valid", 64'(r_valid), 64'(j == 3));
      check("lat_count", 64'(count), (j <= 3) ? 64'd1 : 64'd0);
      if (j == 3) check("lat_r_data", r_data, 64'hA1);
      tick();
    end

    // Fill: 4 RAM + 2 buffer, seventh push refused.
    r_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w_valid = 1'b1; w_data = 64'(i);
      check("fill_w_ready", 64'(w_ready), 64'd1);
      tick();
    end
    w_data = 64'd6;
    check("full_w_ready", 64'(w_ready), 64'd0);
    check("full_count", 64'(count), 64'd6);
    tick();
    check("full_count_hold", 64'(count), 64'd6);
    w_valid = 1'b0; r_ready = 1'b1;
    got = 0;
    for (int n = 0; n < 20 && got < 6; n++) begin
      if (r_valid) begin
        check("drain_data", r_data, 64'(got));
        got++;
      end
      tick();
    end
    check("drain_n", 64'(got), 64'd6);
    check("drain_count", 64'(count), 64'd0);

    // Continuous streaming: no bubbles once data starts flowing.
    pushed = 0; pops = 0; bubbles = 0; seen = 1'b0; k = 0;
    while (pops < 1000 && k < 3000) begin
      w_valid = (pushed < 1000); w_data = {$urandom, $urandom}; r_ready = 1'b1;
      if (w_valid && w_ready) pushed++;
      if (r_valid) begin
        pops++; seen = 1'b1;
      end else if (seen && pushed < 1000) begin
        bubbles++;
      end
      tick();
      k++;
    end
    w_valid = 1'b0;
    check("stream_pops", 64'(pops), 64'd1000);
    check("stream_bubbles", 64'(bubbles), 64'd0);

    // Random 50% traffic on both sides.
    pushed = 0; pops = 0; k = 0;
    while (pops < 10000 && k < 60000) begin
      w_valid = (pushed < 10000) && ($urandom_range(0, 1) == 1);
      w_data  = {$urandom, $urandom};
      r_ready = ($urandom_range(0, 1) == 1);
      if (w_valid && w_ready) pushed++;
      if (r_valid && r_ready) pops++;
      tick();
      k++;
    end
    w_valid = 1'b0; r_ready = 1'b0;
    check("rand_pops", 64'(pops), 64'd10000);

    // Reset with 3 queued entries and a read in flight.
    for (int i = 0; i < 3; i++) begin
      w_valid = 1'b1; w_data = 64'(11 * (i + 1));
      tick();
    end
    w_valid = 1'b0;
    check("pre_rst_count", 64'(count), 64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_r_valid", 64'(r_valid), 64'd0);
    check("mid_rst_count", 64'(count), 64'd0);
    w_valid = 1'b1; w_data = 64'h5; r_ready = 1'b1;
    tick();
    w_valid = 1'b0;
    got = 0;
    for (int n = 0; n < 10 && got == 0; n++) begin
      if (r_valid) begin
        check("post_rst_data", r_data, 64'h5);
        got = 1;
      end
      tick();
    end
    check("post_rst_seen", 64'(got), 64'd1);
    check("post_rst_count", 64'(count), 64'd0);
    check("post_rst_empty", 64'(r_valid), 64'd0);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
